// File: rtl/aca_csu_vl_ctrl.sv
// Variable-latency controller around a 2-bit-block ACA-CSU approximate adder.
// Results are speculative unless exact mode requests a correction cycle on mis-speculation.
module aca_csu_vl_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  output logic             out_corrected,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned N = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, EVAL, CORR, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [N-1:0]     blk_g;
  logic [N-1:0]     blk_p;
  logic [N-1:0]     cin;
  logic [WIDTH:0]   approx;
  logic [WIDTH:0]   exact;
  logic             c_mid;
  logic             c_out;
  logic             err;
  logic             done_hs;

  // Speculative carries look only one block back; a propagating block
  // guesses its carry-in from the generate bit just below it.
  always_comb begin
    p      = a_q ^ b_q;
    g      = a_q & b_q;
    blk_g  = '0;
    blk_p  = '0;
    cin    = '0;
    approx = '0;
    c_mid  = 1'b0;
    c_out  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      blk_g[j] = g[2*j+1] | (p[2*j+1] & g[2*j]);
      blk_p[j] = p[2*j+1] & p[2*j];
    end
    cin[0] = 1'b0;
    cin[1] = blk_g[0];
    for (int unsigned k = 2; k < N; k++) begin
      cin[k] = blk_p[k-1] ? g[2*k-3] : blk_g[k-1];
    end
    for (int unsigned j = 0; j < N; j++) begin
      approx[2*j]   = p[2*j] ^ cin[j];
      c_mid         = g[2*j] | (p[2*j] & cin[j]);
      approx[2*j+1] = p[2*j+1] ^ c_mid;
      c_out         = g[2*j+1] | (p[2*j+1] & c_mid);
    end
    approx[WIDTH] = c_out;
  end

  assign exact   = {1'b0, a_q} + {1'b0, b_q};
  assign err     = (approx != exact);
  assign done_hs = (state == DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = EVAL;
      EVAL: state_nx = (!mode_q || !err) ? DONE : CORR;
      CORR: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      mode_q        <= 1'b0;
      out_sum       <= '0;
      out_err       <= 1'b0;
      out_corrected <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q    <= in_a;
          b_q    <= in_b;
          mode_q <= in_mode;
        end
        EVAL: if (!mode_q || !err) begin
          out_sum       <= approx;
          out_err       <= err;
          out_corrected <= 1'b0;
        end
        CORR: begin
          out_sum       <= exact;
          out_err       <= 1'b1;
          out_corrected <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (clr_stats) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (done_hs) begin
      if (op_count != '1)             op_count  <= op_count + 1'b1;
      if (out_err && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_aca_csu_vl_ctrl.sv
// Directed bench for aca_csu_vl_ctrl; narrow counters so saturation is reachable quickly.
module tb_aca_csu_vl_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    out_sum;
  logic          out_err;
  logic          out_corrected;
  logic          clr_stats;
  logic [CW-1:0] op_count;
  logic [CW-1:0] err_count;

  int vec = 0;
  int mis = 0;
  int exp_ops = 0;
  int exp_errs = 0;

  aca_csu_vl_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .out_corrected(out_corrected),
    .clr_stats(clr_stats), .op_count(op_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One transaction: drive at negedge, measure latency, hold under backpressure, then hand off.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                     input logic [W:0] es, input logic ee, input logic ec,
                     input int el, input int hold, input logic clr);
    int lat;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = a ^ b;
    in_mode  = ~m;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, el);
    chk("out_sum", {23'd0, out_sum}, {23'd0, es});
    chk("out_err", {31'd0, out_err}, {31'd0, ee});
    chk("out_corrected", {31'd0, out_corrected}, {31'd0, ec});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_sum", {23'd0, out_sum}, {23'd0, es});
    end
    out_ready = 1'b1;
    clr_stats = clr;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    clr_stats = 1'b0;
    if (clr) begin
      exp_ops  = 0;
      exp_errs = 0;
    end else begin
      if (exp_ops < CMAX) exp_ops++;
      if (ee && exp_errs < CMAX) exp_errs++;
    end
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_ready", {31'd0, in_ready}, 32'd1);
    chk("op_count", {28'd0, op_count}, exp_ops);
    chk("err_count", {28'd0, err_count}, exp_errs);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {23'd0, out_sum}, 32'd0);
    chk("rst_op_count", {28'd0, op_count}, 32'd0);
    chk("rst_err_count", {28'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(8'h12, 8'h21, 1'b1, 9'h033, 1'b0, 1'b0, 2, 0, 1'b0);
    run(8'h0F, 8'h01, 1'b1, 9'h010, 1'b1, 1'b1, 3, 0, 1'b0);
    run(8'h0F, 8'h01, 1'b0, 9'h000, 1'b1, 1'b0, 2, 0, 1'b0);
    run(8'hFF, 8'h01, 1'b1, 9'h100, 1'b1, 1'b1, 3, 5, 1'b0);

    // Reset while the correction cycle is in flight.
    in_valid = 1'b1;
    in_a     = 8'h0F;
    in_b     = 8'h01;
    in_mode  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("corr_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {23'd0, out_sum}, 32'd0);
    chk("midrst_op_count", {28'd0, op_count}, 32'd0);
    chk("midrst_err_count", {28'd0, err_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops  = 0;
    exp_errs = 0;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
    run(8'h01, 8'h01, 1'b1, 9'h002, 1'b0, 1'b0, 2, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run(8'h0F, 8'h01, 1'b0, 9'h000, 1'b1, 1'b0, 2, 0, 1'b0);
    end
    chk("sat_op_count", {28'd0, op_count}, CMAX);
    chk("sat_err_count", {28'd0, err_count}, CMAX);

    run(8'h0F, 8'h01, 1'b1, 9'h010, 1'b1, 1'b1, 3, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
